// File: rtl/wb_gain.sv
// Per-channel white-balance gain: 2-stage pixel pipeline with frame-synchronous gain switching.
// Optional gray-world statistics are built when the WB_STATS_EN macro is defined.
module wb_gain #(
    parameter int GAIN_W = 12,
    parameter int SUM_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pixel_in,
    input  logic              valid_in,
    input  logic [2:0]        color_in,
    input  logic              last_in,
    input  logic [GAIN_W-1:0] gain_r,
    input  logic [GAIN_W-1:0] gain_g,
    input  logic [GAIN_W-1:0] gain_b,
    input  logic              gain_load,
    output logic [7:0]        pixel_out,
    output logic              valid_out,
    output logic [2:0]        color_out,
    output logic              last_out,
    output logic [SUM_W-1:0]  sum_r,
    output logic [SUM_W-1:0]  sum_g,
    output logic [SUM_W-1:0]  sum_b,
    output logic              stats_valid
);

    localparam int PROD_W = 8 + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Q4.8 product -> round half up -> clamp to 8 bits
    function automatic logic [7:0] round_sat(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] t;
        t = {1'b0, p} + (PROD_W+1)'(128);
        if (|t[PROD_W:16]) return 8'hFF;
        return t[15:8];
    endfunction

    logic [7:0]        pix_p1_q;
    logic              vld_p1_q;
    logic [2:0]        col_p1_q;
    logic              last_p1_q;

    logic [GAIN_W-1:0] shd_r_q, shd_g_q, shd_b_q;
    logic [GAIN_W-1:0] shd_r_d, shd_g_d, shd_b_d;
    logic [GAIN_W-1:0] act_r_q, act_g_q, act_b_q;
    logic [GAIN_W-1:0] act_r_d, act_g_d, act_b_d;

    state_t            state_q, state_d;
    logic              load_act;
    logic              frame_end;

    logic [GAIN_W-1:0] sel_gain;
    logic [PROD_W-1:0] prod_p1;
    logic [7:0]        pix_p2_d;

    logic [7:0]        pix_p2_q;
    logic              vld_p2_q;
    logic [2:0]        col_p2_q;
    logic              last_p2_q;

    // ---- Stage 1: input capture ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            pix_p1_q  <= '0;
            col_p1_q  <= '0;
            last_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= valid_in;
            if (valid_in) begin
                pix_p1_q  <= pixel_in;
                col_p1_q  <= color_in;
                last_p1_q <= last_in;
            end
        end
    end

    assign frame_end = vld_p1_q && last_p1_q;

    // Active gains follow the shadow only between frames; the first pixel's
    // S1 cycle already counts as in-frame so the gain cannot shift under it.
    always_comb begin
        state_d  = state_q;
        load_act = 1'b0;
        case (state_q)
            IDLE: begin
                if (!vld_p1_q) begin
                    load_act = 1'b1;
                end else if (last_p1_q) begin
                    load_act = 1'b1;
                end else begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_end) begin
                    state_d  = IDLE;
                    load_act = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Active copies shadow's next value so a coincident load lands immediately
    always_comb begin
        shd_r_d = gain_load ? gain_r : shd_r_q;
        shd_g_d = gain_load ? gain_g : shd_g_q;
        shd_b_d = gain_load ? gain_b : shd_b_q;
        act_r_d = load_act ? shd_r_d : act_r_q;
        act_g_d = load_act ? shd_g_d : act_g_q;
        act_b_d = load_act ? shd_b_d : act_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_r_q <= UNITY;
            shd_g_q <= UNITY;
            shd_b_q <= UNITY;
            act_r_q <= UNITY;
            act_g_q <= UNITY;
            act_b_q <= UNITY;
        end else begin
            shd_r_q <= shd_r_d;
            shd_g_q <= shd_g_d;
            shd_b_q <= shd_b_d;
            act_r_q <= act_r_d;
            act_g_q <= act_g_d;
            act_b_q <= act_b_d;
        end
    end

    always_comb begin
        case (col_p1_q)
            3'd0:    sel_gain = act_r_q;
            3'd1:    sel_gain = act_g_q;
            3'd2:    sel_gain = act_b_q;
            default: sel_gain = UNITY;
        endcase
        prod_p1  = PROD_W'(pix_p1_q) * PROD_W'(sel_gain);
        pix_p2_d = round_sat(prod_p1);
    end

    // ---- Stage 2: gained pixel to output ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            pix_p2_q  <= '0;
            col_p2_q  <= '0;
            last_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                pix_p2_q  <= pix_p2_d;
                col_p2_q  <= col_p1_q;
                last_p2_q <= last_p1_q;
            end
        end
    end

    assign pixel_out = pix_p2_q;
    assign valid_out = vld_p2_q;
    assign color_out = col_p2_q;
    assign last_out  = last_p2_q;

`ifdef WB_STATS_EN
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [7:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W+1)'(b);
        if (s[SUM_W]) return '1;
        return s[SUM_W-1:0];
    endfunction

    logic [SUM_W-1:0] acc_r_q, acc_g_q, acc_b_q;
    logic [SUM_W-1:0] acc_r_d, acc_g_d, acc_b_d;
    logic [SUM_W-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic             stats_vld_q;

    always_comb begin
        acc_r_d = (vld_p1_q && col_p1_q == 3'd0) ? sat_add(acc_r_q, pix_p1_q) : acc_r_q;
        acc_g_d = (vld_p1_q && col_p1_q == 3'd1) ? sat_add(acc_g_q, pix_p1_q) : acc_g_q;
        acc_b_d = (vld_p1_q && col_p1_q == 3'd2) ? sat_add(acc_b_q, pix_p1_q) : acc_b_q;
    end

    // Publishing on the S1 edge makes the pulse line up with last_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r_q     <= '0;
            acc_g_q     <= '0;
            acc_b_q     <= '0;
            sum_r_q     <= '0;
            sum_g_q     <= '0;
            sum_b_q     <= '0;
            stats_vld_q <= 1'b0;
        end else begin
            stats_vld_q <= frame_end;
            if (frame_end) begin
                sum_r_q <= acc_r_d;
                sum_g_q <= acc_g_d;
                sum_b_q <= acc_b_d;
                acc_r_q <= '0;
                acc_g_q <= '0;
                acc_b_q <= '0;
            end else begin
                acc_r_q <= acc_r_d;
                acc_g_q <= acc_g_d;
                acc_b_q <= acc_b_d;
            end
        end
    end

    assign sum_r       = sum_r_q;
    assign sum_g       = sum_g_q;
    assign sum_b       = sum_b_q;
    assign stats_valid = stats_vld_q;
`else
    assign sum_r       = '0;
    assign sum_g       = '0;
    assign sum_b       = '0;
    assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gain.sv
// Directed bench for wb_gain: vector table for the gain arithmetic plus
// sequences for frame-boundary gain switching, statistics and mid-frame reset.
module tb_wb_gain;

    localparam int GAIN_W = 12;
    localparam int SUM_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        pixel_in;
    logic              valid_in;
    logic [2:0]        color_in;
    logic              last_in;
    logic [GAIN_W-1:0] gain_r, gain_g, gain_b;
    logic              gain_load;
    logic [7:0]        pixel_out;
    logic              valid_out;
    logic [2:0]        color_out;
    logic              last_out;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic              stats_valid;

    always #5 clk = ~clk;

    wb_gain #(.GAIN_W(GAIN_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst),
        .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in), .last_in(last_in),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .gain_load(gain_load),
        .pixel_out(pixel_out), .valid_out(valid_out), .color_out(color_out), .last_out(last_out),
        .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b), .stats_valid(stats_valid)
    );

    typedef struct {
        logic [7:0]        pix;
        logic [2:0]        col;
        logic [GAIN_W-1:0] gr, gg, gb;
        logic [7:0]        exp;
    } vec_t;

    typedef struct packed {
        logic       last;
        logic [2:0] col;
        logic [7:0] pix;
    } out_t;

    typedef struct {
        logic [SUM_W-1:0] r, g, b;
        logic             with_last;
    } st_t;

    localparam int NV = 10;
    vec_t vecs[NV];
    out_t outq[$];
    st_t  stq[$];
    st_t  mon_s;

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic [2:0] c, input logic l);
        valid_in = v;
        pixel_in = p;
        color_in = c;
        last_in  = l;
    endtask

    task automatic load_idle(input logic [GAIN_W-1:0] r, input logic [GAIN_W-1:0] g,
                             input logic [GAIN_W-1:0] b);
        gain_r = r; gain_g = g; gain_b = b;
        gain_load = 1'b1;
        step();
        gain_load = 1'b0;
        step();
    endtask

    task automatic setv(input int i, input logic [7:0] p, input logic [2:0] c,
                        input logic [GAIN_W-1:0] r, input logic [GAIN_W-1:0] g,
                        input logic [GAIN_W-1:0] b, input logic [7:0] e);
        vecs[i].pix = p; vecs[i].col = c;
        vecs[i].gr = r; vecs[i].gg = g; vecs[i].gb = b;
        vecs[i].exp = e;
    endtask

    // Output monitor, sampled on the falling edge
    always begin
        @(negedge clk);
        if (valid_out) outq.push_back({last_out, color_out, pixel_out});
        if (stats_valid) begin
            mon_s.r = sum_r;
            mon_s.g = sum_g;
            mon_s.b = sum_b;
            mon_s.with_last = valid_out && last_out;
            stq.push_back(mon_s);
        end
    end

    initial begin
        logic [7:0] fb_exp[5];
        logic [7:0] co_exp[3];

        setv(0, 8'd100, 3'd0, 12'd384,  12'd256,  12'd256,  8'd150);
        setv(1, 8'd200, 3'd2, 12'd256,  12'd256,  12'd512,  8'd255);
        setv(2, 8'd1,   3'd1, 12'd256,  12'd128,  12'd256,  8'd1);
        setv(3, 8'd1,   3'd1, 12'd256,  12'd127,  12'd256,  8'd0);
        setv(4, 8'd77,  3'd5, 12'd512,  12'd512,  12'd512,  8'd77);
        setv(5, 8'd255, 3'd1, 12'd256,  12'd257,  12'd256,  8'd255);
        setv(6, 8'd254, 3'd1, 12'd256,  12'd257,  12'd256,  8'd255);
        setv(7, 8'd3,   3'd0, 12'd100,  12'd256,  12'd256,  8'd1);
        setv(8, 8'd255, 3'd2, 12'd256,  12'd256,  12'd4095, 8'd255);
        setv(9, 8'd0,   3'd7, 12'd4095, 12'd4095, 12'd4095, 8'd0);

        rst = 1'b1;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        gain_r = '0; gain_g = '0; gain_b = '0; gain_load = 1'b0;
        step(); step();
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_color_out", color_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_stats_valid", stats_valid, 0);
        chk("rst_sum_r", sum_r, 0);
        chk("rst_sum_b", sum_b, 0);
        rst = 1'b0;
        step();

        // Single-pixel frames: gain arithmetic and exact 2-cycle latency
        for (int i = 0; i < NV; i++) begin
            gain_r = vecs[i].gr; gain_g = vecs[i].gg; gain_b = vecs[i].gb;
            gain_load = 1'b1;
            step();
            gain_load = 1'b0;
            drive(1'b1, vecs[i].pix, vecs[i].col, 1'b1);
            step();
            chk($sformatf("v%0d_not_early", i), valid_out, 0);
            drive(1'b0, 8'd0, 3'd0, 1'b0);
            step();
            chk($sformatf("v%0d_valid", i), valid_out, 1);
            chk($sformatf("v%0d_pixel", i), pixel_out, vecs[i].exp);
            chk($sformatf("v%0d_color", i), color_out, vecs[i].col);
            chk($sformatf("v%0d_last", i), last_out, 1);
            step();
            chk($sformatf("v%0d_bubble", i), valid_out, 0);
        end

        // Mid-frame gain_load waits for the boundary; next frame follows back-to-back
        load_idle(12'd256, 12'd256, 12'd256);
        outq.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd100, 3'd0, i == 3);
            if (i == 1) begin
                gain_r = 12'd512;
                gain_load = 1'b1;
            end else begin
                gain_load = 1'b0;
            end
            step();
        end
        gain_load = 1'b0;
        drive(1'b1, 8'd100, 3'd0, 1'b1);
        step();
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        step(); step(); step();
        fb_exp = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd200};
        chk("fb_count", outq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < outq.size()) begin
                chk($sformatf("fb_pix%0d", i), outq[i].pix, fb_exp[i]);
                chk($sformatf("fb_last%0d", i), outq[i].last, (i >= 3) ? 1 : 0);
            end
        end

        // gain_load while the last pixel sits in S1, next frame immediately behind
        load_idle(12'd256, 12'd256, 12'd256);
        outq.delete();
        drive(1'b1, 8'd50, 3'd1, 1'b0);
        step();
        drive(1'b1, 8'd50, 3'd1, 1'b1);
        step();
        drive(1'b1, 8'd50, 3'd1, 1'b1);
        gain_g = 12'd512;
        gain_load = 1'b1;
        step();
        gain_load = 1'b0;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        step(); step(); step();
        co_exp = '{8'd50, 8'd50, 8'd100};
        chk("co_count", outq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < outq.size()) chk($sformatf("co_pix%0d", i), outq[i].pix, co_exp[i]);
        end

        // Statistics frame, then a one-pixel frame
        load_idle(12'd256, 12'd256, 12'd256);
        stq.delete();
        drive(1'b1, 8'd10, 3'd0, 1'b0); step();
        drive(1'b1, 8'd20, 3'd0, 1'b0); step();
        drive(1'b1, 8'd30, 3'd1, 1'b0); step();
        drive(1'b1, 8'd40, 3'd2, 1'b0); step();
        drive(1'b1, 8'd50, 3'd2, 1'b1); step();
        drive(1'b1, 8'd1,  3'd0, 1'b1); step();
        drive(1'b0, 8'd0,  3'd0, 1'b0);
        step(); step(); step();
`ifdef WB_STATS_EN
        chk("st_pulses", stq.size(), 2);
        if (stq.size() >= 2) begin
            chk("st0_sum_r", stq[0].r, 30);
            chk("st0_sum_g", stq[0].g, 30);
            chk("st0_sum_b", stq[0].b, 90);
            chk("st0_with_last", stq[0].with_last, 1);
            chk("st1_sum_r", stq[1].r, 1);
            chk("st1_sum_g", stq[1].g, 0);
            chk("st1_sum_b", stq[1].b, 0);
        end
        chk("st_hold_sum_r", sum_r, 1);
`else
        chk("st_no_pulses", stq.size(), 0);
        chk("st_sum_r_tied", sum_r, 0);
        chk("st_sum_b_tied", sum_b, 0);
`endif

        // Reset in the middle of a frame with a pending shadow load
        load_idle(12'd512, 12'd256, 12'd256);
        drive(1'b1, 8'd100, 3'd0, 1'b0);
        step();
        drive(1'b1, 8'd100, 3'd0, 1'b0);
        gain_r = 12'd1024;
        gain_load = 1'b1;
        step();
        gain_load = 1'b0;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        chk("mr_pre_pixel", pixel_out, 200);
        rst = 1'b1;
        #1;
        chk("mr_pixel_out", pixel_out, 0);
        chk("mr_valid_out", valid_out, 0);
        chk("mr_color_out", color_out, 0);
        chk("mr_last_out", last_out, 0);
        chk("mr_stats_valid", stats_valid, 0);
        chk("mr_sum_r", sum_r, 0);
        step();
        rst = 1'b0;
        step();
        outq.delete();
        stq.delete();
        drive(1'b1, 8'd5, 3'd0, 1'b1);
        step();
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        step(); step(); step();
        chk("mr_out_count", outq.size(), 1);
        if (outq.size() >= 1) chk("mr_pixel", outq[0].pix, 5);
`ifdef WB_STATS_EN
        chk("mr_stats_count", stq.size(), 1);
        if (stq.size() >= 1) chk("mr_stats_sum_r", stq[0].r, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/wb_gain.md
# wb_gain

Per-channel white-balance gain stage placed directly upstream of the gamma-2.2 LUT stage. It consumes the demosaiced pixel stream (pixel, valid, color, last) and applies a fixed-point gain selected by `color_in`. It rounds and saturates the result to 8 bits and emits the same stream format for the gamma stage. Gains are double-buffered so they change only on frame boundaries. Optional gray-world statistics (per-channel sums) are produced once per frame.

## Interface

- `GAIN_W`, 12: gain width, unsigned Q4.8 (256 = 1.0).
- `SUM_W`, 32: statistics accumulator width.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `pixel_in`  in  8  input pixel
- `valid_in`  in  1  pixel qualifier
- `color_in`  in  3  channel: 0=R, 1=G, 2=B, other=passthrough
- `last_in`  in  1  last pixel of frame; valid only with `valid_in`
- `gain_r`, `gain_g`, `gain_b`  in  GAIN_W each  new gains, sampled on `gain_load`
- `gain_load`  in  1  one-cycle request to load new gains
- `pixel_out`  out  8  gained pixel
- `valid_out`  out  1  output qualifier
- `color_out`  out  3  delayed `color_in`
- `last_out`  out  1  delayed `last_in`
- `sum_r`, `sum_g`, `sum_b`  out  SUM_W each  previous-frame pre-gain channel sums
- `stats_valid`  out  1  one-cycle pulse; sums updated

## Operation

- **Stage 1 (S1):** registers `pixel_in`, `valid_in`, `color_in`, and `last_in`.
- **Stage 2 (S2):** computes `p = S1.pixel * gain[S1.color]` (20-bit). It then forms `(p + 128) >> 8` and saturates to 255. The result, together with the delayed valid, color and last, is registered to the outputs.
- Color codes 3..7 use gain 256, so the pixel passes through unchanged.
- Gains are held in shadow and active register sets. Both reset to 256.
- On `gain_load`, the shadow set captures `gain_r`/`gain_g`/`gain_b`.
- Frame state machine:
  - IDLE → ACTIVE on the first S1 valid pixel.
  - ACTIVE → IDLE when S1 holds a valid pixel with `last` set.
  - The active set is loaded from the shadow set on every clock edge while in IDLE, and on the ACTIVE → IDLE edge. It never changes mid-frame.
- `gain_load` coincident with the boundary edge: the newly sampled values become active. Shadow and active are written on the same edge, and the active write uses the input values.
- Stats (`WB_STATS_EN`):
  - Accumulators add S1.pixel for each valid R/G/B pixel and saturate at 2^SUM_W − 1.
  - On the S1 last pixel, that pixel is included, the totals are copied to `sum_*`, and the accumulators clear.
- `valid_in` low: pipeline bubbles propagate. S2 data registers hold their values; `valid_out` is 0.

## Timing

- Latency is 2 cycles from `valid_in` to `valid_out`. Throughput is 1 pixel/cycle with no backpressure.
- Reset values:
  - `pixel_out`, `valid_out`, `color_out`, `last_out`, `stats_valid`: 0.
  - `sum_*`: 0.
  - Gains: 256.
  - State: IDLE.
- Reset mid-frame aborts the frame. Accumulators clear and pending shadow gains are lost (reset to 256).
- `stats_valid` pulses in the same cycle as `last_out`. `sum_*` hold their value until the next pulse.
- A gain applies to a pixel if it was active while that pixel was in S1.
- Back-to-back frames (last followed immediately by a first pixel) are supported. The next frame's first pixel sees the updated gains.

## Configuration

- `WB_STATS_EN` defined: accumulators, `sum_*` and `stats_valid` are implemented as above.
- `WB_STATS_EN` undefined: no accumulator logic. `sum_*` are tied to 0 and `stats_valid` is tied to 0. Ports remain present. Pixel path is unchanged.

## Test plan

- **Basic gain:** reset; R pixel 100 with gain_r=384 → `pixel_out`=150, color 0, exactly 2 cycles after input.
- **Saturation and rounding:**
  - B 200 with gain_b=512 → 255.
  - G 1 with gain_g=128 → 1.
  - G 1 with gain_g=127 → 0.
  - Color 5, pixel 77 → 77.
- **Frame-boundary gain switch:** frame of 4 R pixels of 100 with gain_r=256; `gain_load` with gain_r=512 at pixel 2 → outputs 100,100,100,100. The next frame's R 100 → 200.
- **Coincident load:** `gain_load` with gain_g=512 in the cycle the last pixel sits in S1 → the next frame's G 50 → 100.
- **Stats (`WB_STATS_EN`):** frame R{10,20}, G{30}, B{40,50} with last on B 50 → `stats_valid` with `last_out`; `sum_r`=30, `sum_g`=30, `sum_b`=90. Next frame R{1} → `sum_r`=1.
- **Reset mid-frame:** assert `rst` after 2 of 4 pixels → all outputs 0 and gains 256. A new frame R{5} → `sum_r`=5 and `pixel_out`=5.
